// File: rtl/control_unit_if.sv
// Control bus between the RISC-SPM sequencer and its datapath.
// The instruction and zero flag flow into the sequencer. The load, increment,
// select and write strobes flow out to the datapath.
interface control_unit_if #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned SEL1_SIZE = 3,
    parameter int unsigned SEL2_SIZE = 2
);
    logic [WORD_SIZE-1:0] instruction;
    logic                 zero;
    logic                 load_R0;
    logic                 load_R1;
    logic                 load_R2;
    logic                 load_R3;
    logic                 load_PC;
    logic                 inc_PC;
    logic [SEL1_SIZE-1:0] sel_bus_1_mux;
    logic [SEL2_SIZE-1:0] sel_bus_2_mux;
    logic                 load_IR;
    logic                 load_Add_R;
    logic                 load_Reg_Y;
    logic                 load_Reg_Z;
    logic                 write;

    // Sequencer side: it receives the decode inputs and drives the strobes.
    modport master (
        input  instruction, zero,
        output load_R0, load_R1, load_R2, load_R3, load_PC, inc_PC,
               sel_bus_1_mux, sel_bus_2_mux, load_IR, load_Add_R,
               load_Reg_Y, load_Reg_Z, write
    );

    // Datapath side.
    modport slave (
        output instruction, zero,
        input  load_R0, load_R1, load_R2, load_R3, load_PC, inc_PC,
               sel_bus_1_mux, sel_bus_2_mux, load_IR, load_Add_R,
               load_Reg_Y, load_Reg_Z, write
    );
endinterface

// File: rtl/control_unit.sv
// RISC-SPM control unit: fetch / decode / execute sequencer.
// The strobes are decoded combinationally from the state. In the decode state
// they also depend on the opcode and the zero flag, so that a branch-on-zero
// that is not taken can skip its address byte in the same cycle.
module control_unit #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned SEL1_SIZE = 3,
    parameter int unsigned SEL2_SIZE = 2
) (
    input  logic              clk,
    input  logic              clr,
    control_unit_if.master    bus
);
    localparam int unsigned STATE_W = 4;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned REG_W   = 2;
    localparam int unsigned NUM_REG = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 4'd0;
    localparam logic [OPC_W-1:0] OP_ADD = 4'd1;
    localparam logic [OPC_W-1:0] OP_SUB = 4'd2;
    localparam logic [OPC_W-1:0] OP_AND = 4'd3;
    localparam logic [OPC_W-1:0] OP_NOT = 4'd4;
    localparam logic [OPC_W-1:0] OP_RD  = 4'd5;
    localparam logic [OPC_W-1:0] OP_WR  = 4'd6;
    localparam logic [OPC_W-1:0] OP_BR  = 4'd7;
    localparam logic [OPC_W-1:0] OP_BRZ = 4'd8;

    localparam logic [SEL1_SIZE-1:0] SEL1_PC  = SEL1_SIZE'(4);
    localparam logic [SEL2_SIZE-1:0] SEL2_ALU = SEL2_SIZE'(0);
    localparam logic [SEL2_SIZE-1:0] SEL2_B1  = SEL2_SIZE'(1);
    localparam logic [SEL2_SIZE-1:0] SEL2_MEM = SEL2_SIZE'(2);

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EX1  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [OPC_W-1:0]       w_opcode;
    logic [REG_W-1:0]       w_src;
    logic [REG_W-1:0]       w_dest;

    logic [NUM_REG-1:0]     w_load_r;
    logic                   w_load_pc;
    logic                   w_inc_pc;
    logic [SEL1_SIZE-1:0]   w_sel1;
    logic [SEL2_SIZE-1:0]   w_sel2;
    logic                   w_load_ir;
    logic                   w_load_add_r;
    logic                   w_load_reg_y;
    logic                   w_load_reg_z;
    logic                   w_write;

    assign w_opcode = bus.instruction[7:4];
    assign w_src    = bus.instruction[3:2];
    assign w_dest   = bus.instruction[1:0];

    // State register. When clr goes low it returns the sequencer to idle at once.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobe decode. Every strobe defaults to 0 before the case.
    always_comb begin
        w_next_state = S_IDLE;
        w_load_r     = '0;
        w_load_pc    = 1'b0;
        w_inc_pc     = 1'b0;
        w_sel1       = '0;
        w_sel2       = '0;
        w_load_ir    = 1'b0;
        w_load_add_r = 1'b0;
        w_load_reg_y = 1'b0;
        w_load_reg_z = 1'b0;
        w_write      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_next_state = S_FET1;
            end
            S_FET1: begin
                w_sel1       = SEL1_PC;
                w_sel2       = SEL2_B1;
                w_load_add_r = 1'b1;
                w_next_state = S_FET2;
            end
            S_FET2: begin
                w_sel2       = SEL2_MEM;
                w_load_ir    = 1'b1;
                w_inc_pc     = 1'b1;
                w_next_state = S_DEC;
            end
            S_DEC: begin
                case (w_opcode)
                    OP_NOP: begin
                        w_next_state = S_FET1;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        w_sel1       = SEL1_SIZE'(w_src);
                        w_sel2       = SEL2_B1;
                        w_load_reg_y = 1'b1;
                        w_next_state = S_EX1;
                    end
                    OP_NOT: begin
                        w_sel1           = SEL1_SIZE'(w_src);
                        w_sel2           = SEL2_ALU;
                        w_load_reg_z     = 1'b1;
                        w_load_r[w_dest] = 1'b1;
                        w_next_state     = S_FET1;
                    end
                    OP_RD: begin
                        w_sel1       = SEL1_PC;
                        w_sel2       = SEL2_B1;
                        w_load_add_r = 1'b1;
                        w_next_state = S_RD1;
                    end
                    OP_WR: begin
                        w_sel1       = SEL1_PC;
                        w_sel2       = SEL2_B1;
                        w_load_add_r = 1'b1;
                        w_next_state = S_WR1;
                    end
                    OP_BR: begin
                        w_sel1       = SEL1_PC;
                        w_sel2       = SEL2_B1;
                        w_load_add_r = 1'b1;
                        w_next_state = S_BR1;
                    end
                    OP_BRZ: begin
                        if (bus.zero) begin
                            w_sel1       = SEL1_PC;
                            w_sel2       = SEL2_B1;
                            w_load_add_r = 1'b1;
                            w_next_state = S_BR1;
                        end else begin
                            // Not taken: step the PC past the branch address byte.
                            w_inc_pc     = 1'b1;
                            w_next_state = S_FET1;
                        end
                    end
                    default: begin
                        w_next_state = S_HALT;
                    end
                endcase
            end
            S_EX1: begin
                w_sel1           = SEL1_SIZE'(w_dest);
                w_sel2           = SEL2_ALU;
                w_load_reg_z     = 1'b1;
                w_load_r[w_dest] = 1'b1;
                w_next_state     = S_FET1;
            end
            S_RD1: begin
                w_sel2       = SEL2_MEM;
                w_load_add_r = 1'b1;
                w_inc_pc     = 1'b1;
                w_next_state = S_RD2;
            end
            S_RD2: begin
                w_sel2           = SEL2_MEM;
                w_load_r[w_dest] = 1'b1;
                w_next_state     = S_FET1;
            end
            S_WR1: begin
                w_sel2       = SEL2_MEM;
                w_load_add_r = 1'b1;
                w_inc_pc     = 1'b1;
                w_next_state = S_WR2;
            end
            S_WR2: begin
                w_sel1       = SEL1_SIZE'(w_src);
                w_write      = 1'b1;
                w_next_state = S_FET1;
            end
            S_BR1: begin
                w_sel2       = SEL2_MEM;
                w_load_add_r = 1'b1;
                w_next_state = S_BR2;
            end
            S_BR2: begin
                w_sel2       = SEL2_MEM;
                w_load_pc    = 1'b1;
                w_next_state = S_FET1;
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Drive the datapath strobes onto the bus.
    assign bus.load_R0       = w_load_r[0];
    assign bus.load_R1       = w_load_r[1];
    assign bus.load_R2       = w_load_r[2];
    assign bus.load_R3       = w_load_r[3];
    assign bus.load_PC       = w_load_pc;
    assign bus.inc_PC        = w_inc_pc;
    assign bus.sel_bus_1_mux = w_sel1;
    assign bus.sel_bus_2_mux = w_sel2;
    assign bus.load_IR       = w_load_ir;
    assign bus.load_Add_R    = w_load_add_r;
    assign bus.load_Reg_Y    = w_load_reg_y;
    assign bus.load_Reg_Z    = w_load_reg_z;
    assign bus.write         = w_write;
endmodule
